mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_ctrl.sv | 78 +++++++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: controller state encoding and
// the access timeout limit.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Data-memory access controller for the MEM stage: IDLE/ACCESS FSM, request drive,
// stall generation and optional access timeout (enabled by MEM_TIMEOUT_EN).
module mem_ctrl
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memop,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        timeout,
  output logic        mem_err,
  output mem_state_e  state
);

  // Handshake: mem_req stays high with addr/we/wdata stable until a cycle in
  // which mem_ack is high; that cycle completes the access. mem_ack is ignored in IDLE.
  mem_state_e state_q, state_d;
  logic       done;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  // A stuck access is forced to complete once the counter sits at the limit.
  always_comb begin
    timeout   = (state_q == ACCESS) && !mem_ack && (cnt_q == TIMEOUT_LIMIT);
    cnt_d     = '0;
    if ((state_q == ACCESS) && !mem_ack && !timeout) cnt_d = cnt_q + 4'd1;
    mem_err_d = mem_err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    done      = (state_q == ACCESS) && (mem_ack || timeout);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (memop) state_d = ACCESS;
      ACCESS:  if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req   = (state_q == ACCESS);
    mem_we    = mem_req & mem_write;
    mem_addr  = mem_req ? addr  : '0;
    mem_wdata = mem_req ? wdata : '0;
    stall     = memop & ~done;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around the mem_ctrl access
// controller. Optional access timeout is built when MEM_TIMEOUT_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemToReg_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic        RegWrite_wb,
  output logic        Stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        MemErr,
  output mem_state_e  state_dbg
);

  logic        reg_write_mem_q, reg_write_mem_d;
  logic        mem_read_mem_q, mem_read_mem_d;
  logic        mem_write_mem_q, mem_write_mem_d;
  logic        mem_to_reg_mem_q, mem_to_reg_mem_d;
  logic [4:0]  rd_mem_q, rd_mem_d;
  logic [31:0] alu_mem_q, alu_mem_d;
  logic [31:0] wdata_mem_q, wdata_mem_d;
  logic        reg_write_wb_q, reg_write_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] data_wb_q, data_wb_d;
  logic        stall;
  logic        timeout;
  logic [31:0] rdata_eff;

  mem_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .memop     (mem_read_mem_q | mem_write_mem_q),
    .mem_write (mem_write_mem_q),
    .addr      (alu_mem_q),
    .wdata     (wdata_mem_q),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .timeout   (timeout),
    .mem_err   (MemErr),
    .state     (state_dbg)
  );

  // A timed-out load returns zero rather than whatever is on the bus.
  assign rdata_eff = timeout ? 32'd0 : mem_rdata;

  always_comb begin
    reg_write_mem_d  = reg_write_mem_q;
    mem_read_mem_d   = mem_read_mem_q;
    mem_write_mem_d  = mem_write_mem_q;
    mem_to_reg_mem_d = mem_to_reg_mem_q;
    rd_mem_d         = rd_mem_q;
    alu_mem_d        = alu_mem_q;
    wdata_mem_d      = wdata_mem_q;
    reg_write_wb_d   = 1'b0;
    rd_wb_d          = rd_wb_q;
    data_wb_d        = data_wb_q;
    if (!stall) begin
      reg_write_mem_d  = RegWrite_ex;
      mem_read_mem_d   = MemRead_ex;
      mem_write_mem_d  = MemWrite_ex;
      mem_to_reg_mem_d = MemToReg_ex;
      rd_mem_d         = RegWriteAddr_ex;
      alu_mem_d        = ALUResult_ex;
      wdata_mem_d      = MemWriteData_ex;
      reg_write_wb_d   = reg_write_mem_q;
      rd_wb_d          = rd_mem_q;
      data_wb_d        = mem_to_reg_mem_q ? rdata_eff : alu_mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_mem_q  <= 1'b0;
      mem_read_mem_q   <= 1'b0;
      mem_write_mem_q  <= 1'b0;
      mem_to_reg_mem_q <= 1'b0;
      rd_mem_q         <= '0;
      alu_mem_q        <= '0;
      wdata_mem_q      <= '0;
      reg_write_wb_q   <= 1'b0;
      rd_wb_q          <= '0;
      data_wb_q        <= '0;
    end else begin
      reg_write_mem_q  <= reg_write_mem_d;
      mem_read_mem_q   <= mem_read_mem_d;
      mem_write_mem_q  <= mem_write_mem_d;
      mem_to_reg_mem_q <= mem_to_reg_mem_d;
      rd_mem_q         <= rd_mem_d;
      alu_mem_q        <= alu_mem_d;
      wdata_mem_q      <= wdata_mem_d;
      reg_write_wb_q   <= reg_write_wb_d;
      rd_wb_q          <= rd_wb_d;
      data_wb_q        <= data_wb_d;
    end
  end

  assign ALUResult_mem    = alu_mem_q;
  assign RegWriteAddr_mem = rd_mem_q;
  assign RegWrite_mem     = reg_write_mem_q;
  assign RegWriteData_wb  = data_wb_q;
  assign RegWriteAddr_wb  = rd_wb_q;
  assign RegWrite_wb      = reg_write_wb_q;
  assign Stall_mem        = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: ALU vector table, memory-access sequences,
// reset abandonment and (with MEM_TIMEOUT_EN) the access timeout.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite_ex = 1'b0, MemRead_ex = 1'b0, MemWrite_ex = 1'b0, MemToReg_ex = 1'b0;
  logic [4:0]  RegWriteAddr_ex = '0;
  logic [31:0] ALUResult_ex = '0, MemWriteData_ex = '0;
  logic [31:0] ALUResult_mem, RegWriteData_wb, mem_addr, mem_wdata;
  logic [4:0]  RegWriteAddr_mem, RegWriteAddr_wb;
  logic        RegWrite_mem, RegWrite_wb, Stall_mem, mem_req, mem_we, MemErr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  mem_state_e  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_e;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
  } alu_vec_t;
  alu_vec_t vecs[6];

  mem_stage dut (
    .clk(clk), .reset(reset),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemToReg_ex(MemToReg_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .ALUResult_mem(ALUResult_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_mem(RegWrite_mem), .RegWriteData_wb(RegWriteData_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
    .Stall_mem(Stall_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .MemErr(MemErr), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; MemToReg_ex = m2r;
    RegWriteAddr_ex = rd; ALUResult_ex = alu; MemWriteData_ex = wd;
  endtask

  task automatic set_nop();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Called right after the op enters EX/MEM; ends one cycle after the ack edge.
  task automatic serve(input int waits, input logic [31:0] rdata, input logic [31:0] ea,
                       input logic ewe, input logic [31:0] ewd, input int exp_stalls);
    int stalls;
    stalls = 0;
    check("idle_stall", {31'd0, Stall_mem}, 32'd1);
    check("idle_req", {31'd0, mem_req}, 32'd0);
    if (Stall_mem) stalls++;
    tick();
    for (int i = 0; i < waits; i++) begin
      check("acc_req", {31'd0, mem_req}, 32'd1);
      check("acc_addr", mem_addr, ea);
      check("acc_we", {31'd0, mem_we}, {31'd0, ewe});
      if (ewe) check("acc_wdata", mem_wdata, ewd);
      check("acc_wb_bubble", {31'd0, RegWrite_wb}, 32'd0);
      if (Stall_mem) stalls++;
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = rdata;
    #1;
    check("ack_req", {31'd0, mem_req}, 32'd1);
    check("ack_addr", mem_addr, ea);
    check("ack_we", {31'd0, mem_we}, {31'd0, ewe});
    check("ack_stall", {31'd0, Stall_mem}, 32'd0);
    if (Stall_mem) stalls++;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("stall_cycles", stalls, exp_stalls);
    check("post_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_mem"}, ALUResult_mem, 32'd0);
    check({tag, "_rd_mem"}, {27'd0, RegWriteAddr_mem}, 32'd0);
    check({tag, "_rw_mem"}, {31'd0, RegWrite_mem}, 32'd0);
    check({tag, "_data_wb"}, RegWriteData_wb, 32'd0);
    check({tag, "_rd_wb"}, {27'd0, RegWriteAddr_wb}, 32'd0);
    check({tag, "_rw_wb"}, {31'd0, RegWrite_wb}, 32'd0);
    check({tag, "_stall"}, {31'd0, Stall_mem}, 32'd0);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_memerr"}, {31'd0, MemErr}, 32'd0);
    check({tag, "_state"}, {31'd0, state_dbg}, {31'd0, IDLE});
  endtask

  // scoreboard: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (RegWrite_wb === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got rd %0d data %h expected no write-back",
                 RegWriteAddr_wb, RegWriteData_wb);
      end else begin
        exp_e = exp_q.pop_front();
        check("wb_rd", {27'd0, RegWriteAddr_wb}, {27'd0, exp_e[36:32]});
        check("wb_data", RegWriteData_wb, exp_e[31:0]);
      end
    end
`ifndef MEM_TIMEOUT_EN
    check("memerr_tied", {31'd0, MemErr}, 32'd0);
`endif
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_0000};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 5'd17, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 5'd1,  32'h8000_0001};
    vecs[5] = '{1'b1, 5'd30, 32'h0F0F_F0F0};

    // reset state
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // ALU ops from the table, back to back
    for (int i = 0; i < 6; i++) begin
      set_ex(vecs[i].rw, 1'b0, 1'b0, 1'b0, vecs[i].rd, vecs[i].alu, 32'd0);
      if (vecs[i].rw) exp_q.push_back({vecs[i].rd, vecs[i].alu});
      tick();
      check("alu_result_mem", ALUResult_mem, vecs[i].alu);
      check("alu_rd_mem", {27'd0, RegWriteAddr_mem}, {27'd0, vecs[i].rd});
      check("alu_rw_mem", {31'd0, RegWrite_mem}, {31'd0, vecs[i].rw});
      check("alu_stall", {31'd0, Stall_mem}, 32'd0);
      check("alu_req", {31'd0, mem_req}, 32'd0);
    end

    // random ALU ops
    for (int i = 0; i < 8; i++) begin
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] v;
      rw = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      v  = $urandom;
      set_ex(rw, 1'b0, 1'b0, 1'b0, rd, v, 32'd0);
      if (rw) exp_q.push_back({rd, v});
      tick();
      check("rnd_alu_mem", ALUResult_mem, v);
      check("rnd_stall", {31'd0, Stall_mem}, 32'd0);
    end
    set_nop();
    tick();

    // load: three ACCESS cycles without ack, then ack with data
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0040, 32'd0);
    exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    tick();
    set_nop();
    serve(3, 32'hDEAD_BEEF, 32'h0000_0040, 1'b0, 32'd0, 4);
    tick();

    // store acked on its first ACCESS cycle; no write-back may follow
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0080, 32'h0000_0055);
    tick();
    set_nop();
    serve(0, 32'h1111_1111, 32'h0000_0080, 1'b1, 32'h0000_0055, 1);
    tick();
    tick();

    // back-to-back loads: second load waits in EX until the first is acked
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0100, 32'd0);
    exp_q.push_back({5'd2, 32'hCAFE_0001});
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0104, 32'd0);
    exp_q.push_back({5'd3, 32'hCAFE_0002});
    serve(1, 32'hCAFE_0001, 32'h0000_0100, 1'b0, 32'd0, 2);
    set_nop();
    serve(2, 32'hCAFE_0002, 32'h0000_0104, 1'b0, 32'd0, 3);
    tick();

    // reset in the middle of an access abandons it
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0200, 32'd0);
    tick();
    set_nop();
    tick();
    check("mid_req", {31'd0, mem_req}, 32'd1);
    check("mid_state", {31'd0, state_dbg}, {31'd0, ACCESS});
    reset = 1'b1;
    tick();
    check_all_zero("abandon");
    reset = 1'b0;
    tick();
    check("after_abandon_req", {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // no ack ever: access completes by timeout with zero data, MemErr sticks
    begin
      int acc;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0300, 32'd0);
      exp_q.push_back({5'd12, 32'h0000_0000});
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      set_nop();
      check("to_idle_stall", {31'd0, Stall_mem}, 32'd1);
      tick();
      acc = 0;
      while (mem_req && acc < 40) begin
        acc++;
        tick();
      end
      check("to_access_cycles", acc, 16);
      check("to_memerr", {31'd0, MemErr}, 32'd1);
      mem_rdata = '0;
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0000_0013, 32'd0);
      exp_q.push_back({5'd13, 32'h0000_0013});
      tick();
      set_nop();
      tick();
      tick();
      check("to_memerr_sticky", {31'd0, MemErr}, 32'd1);
      reset = 1'b1;
      tick();
      check("to_memerr_reset", {31'd0, MemErr}, 32'd0);
      reset = 1'b0;
      tick();
    end
`endif

    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
